// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage_pkg                                                  |
// | Shared CPU fetch types: NOP encoding, FSM states, select codes.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h8B1F_03FF;  // ADD XZR,XZR,XZR

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_PLUS4    = 2'd1,
        PC_TARGET   = 2'd2,
        PC_REDIRECT = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        OUT_BUBBLE = 2'd0,
        OUT_RDATA  = 2'd1,
        OUT_SKID   = 2'd2
    } out_sel_t;

    function automatic logic [63:0] pc_add4(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage_if                                                   |
// | Instruction-memory request/ready handshake.                     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fetch_stage_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/DFF32.sv
`default_nettype none
// +------------------------------------------------------------------+
// | DFF32                                                            |
// | 32-bit enable flop.                                              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module DFF32 (
    input  wire logic        clk,
    input  wire logic        i_en,
    input  wire logic [31:0] i_d,
    output logic      [31:0] o_q
);
    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/DFF64.sv
`default_nettype none
// +------------------------------------------------------------------+
// | DFF64                                                            |
// | 64-bit enable flop.                                              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module DFF64 (
    input  wire logic        clk,
    input  wire logic        i_en,
    input  wire logic [63:0] i_d,
    output logic      [63:0] o_q
);
    logic [63:0] r_q;

    always_ff @(posedge clk) begin
        if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_ctrl                                                       |
// | Fetch FSM: handshake, stall/skid, redirect and next-pc select.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_ctrl
    import fetch_stage_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_stall,
    input  wire logic i_br_taken,
    input  wire logic i_imem_ready,
    output logic      o_imem_req,
    output logic      o_ifid_enable,
    output pc_sel_t   o_pc_sel,
    output logic      o_redirect_en,
    output logic      o_skid_en,
    output out_sel_t  o_out_sel
);
    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        o_imem_req    = 1'b0;
        o_ifid_enable = 1'b0;
        o_pc_sel      = PC_HOLD;
        o_redirect_en = 1'b0;
        o_skid_en     = 1'b0;
        o_out_sel     = OUT_BUBBLE;
        case (r_state)
            BOOT: begin
                o_ifid_enable = !i_stall;
                w_state_nxt   = REQ;
                if (i_br_taken) o_pc_sel = PC_TARGET;
            end
            REQ: begin
                o_imem_req = 1'b1;
                if (i_br_taken) begin
                    o_ifid_enable = 1'b1;
                    if (i_imem_ready) begin
                        o_pc_sel = PC_TARGET;
                    end else begin
                        // Outstanding transaction must finish before the target is fetched
                        o_redirect_en = 1'b1;
                        w_state_nxt   = DRAIN;
                    end
                end else if (i_imem_ready && !i_stall) begin
                    o_ifid_enable = 1'b1;
                    o_out_sel     = OUT_RDATA;
                    o_pc_sel      = PC_PLUS4;
                end else if (i_imem_ready) begin
                    o_skid_en   = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    o_ifid_enable = !i_stall;
                end
            end
            HOLD: begin
                if (i_br_taken) begin
                    o_ifid_enable = 1'b1;
                    o_pc_sel      = PC_TARGET;
                    w_state_nxt   = REQ;
                end else if (!i_stall) begin
                    o_ifid_enable = 1'b1;
                    o_out_sel     = OUT_SKID;
                    o_pc_sel      = PC_PLUS4;
                    w_state_nxt   = REQ;
                end
            end
            DRAIN: begin
                o_imem_req    = 1'b1;
                o_ifid_enable = !i_stall;
                if (i_br_taken) o_redirect_en = 1'b1;
                if (i_imem_ready) begin
                    o_pc_sel    = i_br_taken ? PC_TARGET : PC_REDIRECT;
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
        if (reset) begin
            o_imem_req    = 1'b0;
            o_ifid_enable = 1'b0;
            o_out_sel     = OUT_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= BOOT;
        else       r_state <= w_state_nxt;
    end
endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage                                                      |
// | Instruction fetch: owns the PC and drives the IF/ID inputs.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        stall,
    input  wire logic        br_taken,
    input  wire logic [63:0] br_target,
    fetch_stage_if.master    imem,
    output logic      [63:0] pc_out,
    output logic      [63:0] pc_plus4_out,
    output logic      [31:0] instr_out,
    output logic             ifid_enable
);
    pc_sel_t     w_pc_sel;
    out_sel_t    w_out_sel;
    logic        w_redirect_en;
    logic        w_skid_en;
    logic        w_imem_req;
    logic [63:0] w_pc_d;
    logic [63:0] w_pc_view;
    logic [63:0] r_pc;
    logic [63:0] r_redirect_pc;
    logic [31:0] r_skid_instr;

    fetch_ctrl u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .i_stall       (stall),
        .i_br_taken    (br_taken),
        .i_imem_ready  (imem.imem_ready),
        .o_imem_req    (w_imem_req),
        .o_ifid_enable (ifid_enable),
        .o_pc_sel      (w_pc_sel),
        .o_redirect_en (w_redirect_en),
        .o_skid_en     (w_skid_en),
        .o_out_sel     (w_out_sel)
    );

    always_comb begin
        case (w_pc_sel)
            PC_PLUS4:    w_pc_d = pc_add4(r_pc);
            PC_TARGET:   w_pc_d = br_target;
            PC_REDIRECT: w_pc_d = r_redirect_pc;
            default:     w_pc_d = r_pc;
        endcase
        if (reset) w_pc_d = RESET_PC;
    end

    DFF64 u_pc (
        .clk  (clk),
        .i_en (reset || (w_pc_sel != PC_HOLD)),
        .i_d  (w_pc_d),
        .o_q  (r_pc)
    );

    DFF64 u_redirect_pc (
        .clk  (clk),
        .i_en (reset || w_redirect_en),
        .i_d  (reset ? 64'h0 : br_target),
        .o_q  (r_redirect_pc)
    );

    DFF32 u_skid (
        .clk  (clk),
        .i_en (reset || w_skid_en),
        .i_d  (reset ? 32'h0 : imem.imem_rdata),
        .o_q  (r_skid_instr)
    );

    // The PC only changes on completion or redirect, so it doubles as the held address
    assign imem.imem_req  = w_imem_req;
    assign imem.imem_addr = r_pc;

    assign w_pc_view    = reset ? RESET_PC : r_pc;
    assign pc_out       = w_pc_view;
    assign pc_plus4_out = pc_add4(w_pc_view);

    always_comb begin
        case (w_out_sel)
            OUT_RDATA: instr_out = imem.imem_rdata;
            OUT_SKID:  instr_out = r_skid_instr;
            default:   instr_out = NOP_INSTR;
        endcase
    end
endmodule
`default_nettype wire
